// File: rtl/alu_execute_stage.sv
// alu_execute_stage: single-cycle ALU plus iterative 16-step shift-add MUL,
// feeding the register file write port through a registered write-back pulse.
module alu_execute_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              flag_zero,
    output logic              flag_carry
);

    localparam int unsigned CNT_W   = $clog2(DATA_W);
    localparam int unsigned SHAMT_W = $clog2(DATA_W);
    localparam int unsigned PROD_W  = 2 * DATA_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   acc_step;
    logic [PROD_W-1:0]   mcand;
    logic [DATA_W-1:0]   mplier;
    logic [ADDR_W-1:0]   mul_dest;
    logic                accept;
    logic                mul_last;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic [DATA_W:0]     wide_sum;

    assign accept   = issue_valid && issue_ready;
    assign mul_last = (state == ST_MUL) && (cnt == CNT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave IDLE only for an accepted MUL, return after the last bit
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && (op == OP_MUL)) state_nxt = ST_MUL;
            ST_MUL:  if (mul_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM-derived outputs; ready is masked while reset is asserted
    always_comb begin
        issue_ready = 1'b0;
        busy        = 1'b0;
        issue_ready = (state == ST_IDLE) && rst;
        busy        = (state == ST_MUL);
    end

    // Single-cycle ALU result and carry/borrow
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        wide_sum  = '0;
        case (op)
            OP_ADD: begin
                wide_sum  = (DATA_W + 1)'(src_a) + (DATA_W + 1)'(src_b);
                alu_res   = wide_sum[DATA_W-1:0];
                alu_carry = wide_sum[DATA_W];
            end
            OP_SUB: begin
                wide_sum  = (DATA_W + 1)'(src_a) - (DATA_W + 1)'(src_b);
                alu_res   = wide_sum[DATA_W-1:0];
                alu_carry = wide_sum[DATA_W];
            end
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SHL:  alu_res = src_a << src_b[SHAMT_W-1:0];
            OP_SHR:  alu_res = src_a >> src_b[SHAMT_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: multiplicand is pre-shifted, so bit cnt sits at mplier[0]
    always_comb begin
        acc_step = acc;
        if (mplier[0]) acc_step = acc + mcand;
    end

    // Datapath: operand capture, MUL iteration and registered write-back
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            mul_dest   <= '0;
            wb_en      <= 1'b0;
            wb_dest    <= '0;
            wb_data    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        cnt      <= '0;
                        acc      <= '0;
                        mcand    <= PROD_W'(src_a);
                        mplier   <= src_b;
                        mul_dest <= dest;
                    end else begin
                        wb_en      <= (dest != '0);
                        wb_dest    <= dest;
                        wb_data    <= alu_res;
                        flag_zero  <= (alu_res == '0);
                        flag_carry <= alu_carry;
                    end
                end
            end else begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                if (mul_last) begin
                    wb_en      <= (mul_dest != '0);
                    wb_dest    <= mul_dest;
                    wb_data    <= acc_step[DATA_W-1:0];
                    flag_zero  <= (acc_step[DATA_W-1:0] == '0);
                    flag_carry <= |acc_step[PROD_W-1:DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed testbench for alu_execute_stage.
module tb_alu_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  op;
    logic [3:0]  dest;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        busy;
    logic        flag_zero;
    logic        flag_carry;

    int n_cmp = 0;
    int n_err = 0;

    alu_execute_stage #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .op         (op),
        .dest       (dest),
        .src_a      (src_a),
        .src_b      (src_b),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .busy       (busy),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    always #5 clk = ~clk;

    // Present a request; called at a negedge
    task automatic drive(input logic [2:0] o, input logic [3:0] d,
                         input logic [15:0] a, input logic [15:0] b);
        issue_valid = 1'b1;
        op          = o;
        dest        = d;
        src_a       = a;
        src_b       = b;
    endtask

    task automatic test_reset;
        logic [23:0] got;
        rst = 1'b0;
        drive(3'b000, 4'd1, 16'h0001, 16'h0001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {wb_en, wb_dest, wb_data, flag_zero, flag_carry, busy, issue_ready};
        n_cmp++;
        if (got !== 24'h0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=%h", got, 24'h0);
        end
        rst = 1'b1;
        issue_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({issue_ready, wb_en, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release ready/wb_en/busy got=%b exp=100", {issue_ready, wb_en, busy});
        end
    endtask

    task automatic test_add_sub;
        drive(3'b000, 4'd3, 16'h0F00, 16'h0050);
        @(negedge clk);
        issue_valid = 1'b0;
        n_cmp++;
        if ({wb_en, wb_dest, wb_data, flag_zero, flag_carry} !== {1'b1, 4'd3, 16'h0F50, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL add_basic en=%b dest=%0d data=%h z=%b c=%b exp en=1 dest=3 data=0f50 z=0 c=0",
                     wb_en, wb_dest, wb_data, flag_zero, flag_carry);
        end
        @(negedge clk);
        n_cmp++;
        if ({wb_en, wb_data} !== {1'b0, 16'h0F50}) begin
            n_err++;
            $display("FAIL add_pulse_hold en=%b data=%h exp en=0 data=0f50", wb_en, wb_data);
        end
        drive(3'b000, 4'd4, 16'hFFFF, 16'h0002);
        @(negedge clk);
        issue_valid = 1'b0;
        n_cmp++;
        if ({wb_en, wb_dest, wb_data, flag_carry} !== {1'b1, 4'd4, 16'h0001, 1'b1}) begin
            n_err++;
            $display("FAIL add_carry en=%b dest=%0d data=%h c=%b exp en=1 dest=4 data=0001 c=1",
                     wb_en, wb_dest, wb_data, flag_carry);
        end
        drive(3'b001, 4'd5, 16'h0050, 16'h0F00);
        @(negedge clk);
        issue_valid = 1'b0;
        n_cmp++;
        if ({wb_en, wb_dest, wb_data, flag_carry} !== {1'b1, 4'd5, 16'hF150, 1'b1}) begin
            n_err++;
            $display("FAIL sub_borrow en=%b dest=%0d data=%h c=%b exp en=1 dest=5 data=f150 c=1",
                     wb_en, wb_dest, wb_data, flag_carry);
        end
        @(negedge clk);
        n_cmp++;
        if ({flag_carry, wb_data} !== {1'b1, 16'hF150}) begin
            n_err++;
            $display("FAIL flags_hold c=%b data=%h exp c=1 data=f150", flag_carry, wb_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops  [4] = '{3'b010, 3'b011, 3'b101, 3'b100};
        logic [15:0] av   [4] = '{16'hF0FF, 16'hFF0F, 16'h00FF, 16'hAAAA};
        logic [15:0] bv   [4] = '{16'h0040, 16'h00F0, 16'h0004, 16'hAAAA};
        logic [15:0] expd [4] = '{16'h0040, 16'hFFFF, 16'h0FF0, 16'h0000};
        logic        expz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 4'(i + 1), av[i], bv[i]);
            @(negedge clk);
            n_cmp++;
            if ({wb_en, wb_dest, wb_data, flag_zero, flag_carry} !== {1'b1, 4'(i + 1), expd[i], expz[i], 1'b0}) begin
                n_err++;
                $display("FAIL b2b_%0d en=%b dest=%0d data=%h z=%b c=%b exp en=1 dest=%0d data=%h z=%b c=0",
                         i, wb_en, wb_dest, wb_data, flag_zero, flag_carry, i + 1, expd[i], expz[i]);
            end
        end
        issue_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul;
        int low = 0;
        int bsy = 0;
        int guard = 0;
        drive(3'b111, 4'd7, 16'h0024, 16'h0040);
        @(negedge clk);
        // held ADD request during the multiply
        drive(3'b000, 4'd2, 16'h0001, 16'h0001);
        while (!wb_en && guard < 40) begin
            if (!issue_ready) low++;
            if (busy) bsy++;
            guard++;
            @(negedge clk);
        end
        n_cmp++;
        if (guard >= 40) begin
            n_err++;
            $display("FAIL mul_timeout no wb_en within 40 cycles");
        end
        n_cmp++;
        if (low != 16 || bsy != 16) begin
            n_err++;
            $display("FAIL mul_backpressure ready_low=%0d busy=%0d exp 16/16", low, bsy);
        end
        n_cmp++;
        if ({wb_en, wb_dest, wb_data, flag_carry, issue_ready, busy} !== {1'b1, 4'd7, 16'h0900, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL mul_result en=%b dest=%0d data=%h c=%b rdy=%b busy=%b exp en=1 dest=7 data=0900 c=0 rdy=1 busy=0",
                     wb_en, wb_dest, wb_data, flag_carry, issue_ready, busy);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        n_cmp++;
        if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'd2, 16'h0002}) begin
            n_err++;
            $display("FAIL held_add en=%b dest=%0d data=%h exp en=1 dest=2 data=0002", wb_en, wb_dest, wb_data);
        end
    endtask

    task automatic test_mul_overflow;
        int guard = 0;
        drive(3'b111, 4'd6, 16'hAAAA, 16'h0002);
        @(negedge clk);
        issue_valid = 1'b0;
        while (!wb_en && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        n_cmp++;
        if ({wb_en, wb_dest, wb_data, flag_carry, flag_zero} !== {1'b1, 4'd6, 16'h5554, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL mul_overflow en=%b dest=%0d data=%h c=%b z=%b exp en=1 dest=6 data=5554 c=1 z=0",
                     wb_en, wb_dest, wb_data, flag_carry, flag_zero);
        end
    endtask

    task automatic test_dest0;
        drive(3'b000, 4'd0, 16'h1234, 16'h0001);
        @(negedge clk);
        issue_valid = 1'b0;
        n_cmp++;
        if ({wb_en, wb_dest, wb_data, flag_zero, flag_carry} !== {1'b0, 4'd0, 16'h1235, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL dest0 en=%b dest=%0d data=%h z=%b c=%b exp en=0 dest=0 data=1235 z=0 c=0",
                     wb_en, wb_dest, wb_data, flag_zero, flag_carry);
        end
    endtask

    task automatic test_abort;
        int pulses = 0;
        int busy_seen = 0;
        drive(3'b111, 4'd9, 16'h0003, 16'h0003);
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_precond busy=%b exp 1", busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, issue_ready, wb_en, wb_data} !== {1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL abort_reset busy=%b rdy=%b en=%b data=%h exp 0/0/0/0000", busy, issue_ready, wb_en, wb_data);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wb_en) pulses++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0 || busy_seen != 0 || issue_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_after wb_pulses=%0d busy_cycles=%0d rdy=%b exp 0/0/1", pulses, busy_seen, issue_ready);
        end
    endtask

    initial begin
        rst         = 1'b0;
        issue_valid = 1'b0;
        op          = 3'b000;
        dest        = 4'd0;
        src_a       = 16'h0;
        src_b       = 16'h0;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_mul();
        test_mul_overflow();
        test_dest0();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
